// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage: FSM state encodings, the IF/ID
// payload struct and the NOP bubble instruction.
package fetch_unit_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FIdle = 2'd0,
    FWait = 2'd1,
    FHold = 2'd2,
    FDrop = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_EMPTY = '{instr: NOP, pc: 32'h0, pc4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register, updated one cycle after its controls; priority is
// reset, flush, load, then hold while decode stalls, otherwise insert a bubble.
module fetch_unit_ifid_reg
  import fetch_unit_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  load,
  input  logic  hold,
  input  ifid_t load_data,
  output ifid_t ifid
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ifid <= IFID_EMPTY;
    end else if (flush) begin
      ifid <= IFID_EMPTY;
    end else if (load) begin
      ifid <= load_data;
    end else if (!hold) begin
      // Decode consumed the previous entry and nothing new arrived: bubble,
      // but keep the PCs so the stale entry remains traceable.
      ifid.instr <= NOP;
      ifid.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: one outstanding imem read, response into IF/ID in the response
// cycle; idStall parks the word in a hold buffer, flush discards in-flight data.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] pc4,
  input  logic        flush,
  input  logic        idStall,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic        imemRvalid,
  input  logic [31:0] imemRdata,
  output logic        pcStall,
  output logic [31:0] ifidInstr,
  output logic [31:0] ifidPc,
  output logic [31:0] ifidPc4,
  output logic        ifidValid
);

  fetch_state_e state;
  logic [31:0]  req_pc;
  logic [31:0]  req_pc4;
  logic [31:0]  hold_instr;
  logic         accept;
  logic [31:0]  accept_instr;
  ifid_t        load_data;
  ifid_t        ifid;

  assign imemReq  = rst & (state == FIdle) & ~flush;
  assign imemAddr = pc;

  always_comb begin
    accept       = 1'b0;
    accept_instr = imemRdata;
    if (rst && !flush && !idStall) begin
      if (state == FWait && imemRvalid) begin
        accept = 1'b1;
      end else if (state == FHold) begin
        accept       = 1'b1;
        accept_instr = hold_instr;
      end
    end
  end

  // Flush must release the PC even without an accept, since the PC gives
  // stall priority over the jump.
  assign pcStall = ~(flush | accept);

  assign load_data = '{instr: accept_instr, pc: req_pc, pc4: req_pc4, valid: 1'b1};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= FIdle;
      req_pc     <= 32'h0;
      req_pc4    <= 32'h0;
      hold_instr <= 32'h0;
    end else begin
      case (state)
        FIdle: begin
          if (imemReq && imemReady) begin
            req_pc  <= pc;
            req_pc4 <= pc4;
            state   <= FWait;
          end
        end
        FWait: begin
          if (imemRvalid) begin
            if (flush) begin
              state <= FIdle;
            end else if (idStall) begin
              hold_instr <= imemRdata;
              state      <= FHold;
            end else begin
              state <= FIdle;
            end
          end else if (flush) begin
            state <= FDrop;
          end
        end
        FHold: begin
          if (flush || !idStall) begin
            state <= FIdle;
          end
        end
        FDrop: begin
          // The stale response must be swallowed before a new request can go out.
          if (imemRvalid) begin
            state <= FIdle;
          end
        end
        default: state <= FIdle;
      endcase
    end
  end

  fetch_unit_ifid_reg u_ifid_reg (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .load     (accept),
    .hold     (idStall),
    .load_data(load_data),
    .ifid     (ifid)
  );

  assign ifidInstr = ifid.instr;
  assign ifidPc    = ifid.pc;
  assign ifidPc4   = ifid.pc4;
  assign ifidValid = ifid.valid;

endmodule
